hangman_host_display: RTL and testbench

- Parametrised host-side two-row character display formatter for wireless hangman.
- Consumes guess events from game logic; tracks revealed word, miss history and game outcome.
- Drives two registered COLS-character ASCII rows to the LCD driver.
- Successor to the fixed 5-letter/6-miss host display. Adds:
  - generic word length, miss limit and row width;
  - an explicit game state machine;
  - an accept handshake;
  - centring of row content;
  - suppression of duplicate misses.

---
 rtl/hangman_pkg.sv | 20 ++
 rtl/display_row_center.sv | 27 ++
 rtl/hangman_host_display.sv | 176 +++++++++++++++++
 tb/tb_hangman_host_display.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hangman_pkg.sv
// Shared types and constants for the hangman host display.
package hangman_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StPlay = 2'd1,
    StWin  = 2'd2,
    StLose = 2'd3
  } state_e;

  localparam logic [7:0] SPACE = 8'h20;
  localparam logic [7:0] UNDER = 8'h5F;

  localparam int unsigned WIN_LEN  = 3;
  localparam int unsigned LOSE_LEN = 4;

  localparam logic [8*WIN_LEN-1:0]  WIN_STR  = 24'h57696E;    // "Win"
  localparam logic [8*LOSE_LEN-1:0] LOSE_STR = 32'h4C6F7365;  // "Lose"

endpackage

// File: rtl/display_row_center.sv
// Centres a left-aligned payload of len bytes inside a COLS-byte row padded with spaces.
module display_row_center
  import hangman_pkg::*;
#(
  parameter int unsigned COLS   = 16,
  parameter int unsigned MAXLEN = 16
) (
  input  logic [8*MAXLEN-1:0]          payload,
  input  logic [$clog2(MAXLEN+1)-1:0]  len,
  output logic [8*COLS-1:0]            row
);

  always_comb begin
    int lead;
    int idx;
    lead = (int'(COLS) - int'(len)) / 2;
    idx  = 0;
    row  = {COLS{SPACE}};
    for (int c = 0; c < int'(COLS); c++) begin
      idx = c - lead;
      if (idx >= 0 && idx < int'(len)) begin
        row[8*(int'(COLS)-1-c) +: 8] = payload[8*(int'(MAXLEN)-1-idx) +: 8];
      end
    end
  end

endmodule

// File: rtl/hangman_host_display.sv
// Host-side hangman display: tracks revealed word, miss history and outcome, and
// drives two registered, centred ASCII rows.
module hangman_host_display
  import hangman_pkg::*;
#(
  parameter int unsigned WORD_LEN = 5,
  parameter int unsigned MAX_MISS = 6,
  parameter int unsigned COLS     = 16
) (
  input  logic                          clk,
  input  logic                          nRst,
  input  logic                          new_game,
  input  logic [8*WORD_LEN-1:0]         word,
  input  logic                          evt_valid,
  output logic                          evt_ready,
  input  logic [7:0]                    letter,
  input  logic                          is_mistake,
  input  logic [WORD_LEN-1:0]           hit_mask,
  output logic [8*COLS-1:0]             top,
  output logic [8*COLS-1:0]             bottom,
  output logic [$clog2(MAX_MISS+1)-1:0] miss_count,
  output logic [1:0]                    game_state,
  output logic                          row_update
);

  localparam int unsigned CntW = $clog2(MAX_MISS + 1);
  localparam int unsigned LenW = $clog2(COLS + 1);

  state_e                  state_q, state_d;
  logic [8*WORD_LEN-1:0]   word_q, word_d;
  logic [8*WORD_LEN-1:0]   rev_q, rev_d;
  logic [8*MAX_MISS-1:0]   miss_q, miss_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [8*COLS-1:0]       top_q, top_d;
  logic [8*COLS-1:0]       bot_q, bot_d;
  logic                    ru_q, ru_d;

  logic                    accept;
  logic                    dup;
  logic                    all_rev;
  logic [8*COLS-1:0]       top_pl, bot_pl;
  logic [LenW-1:0]         top_len, bot_len;

  assign evt_ready = (state_q == StPlay) && !new_game;
  assign accept    = evt_valid && evt_ready;

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    rev_d   = rev_q;
    miss_d  = miss_q;
    cnt_d   = cnt_q;
    dup     = 1'b0;
    all_rev = 1'b1;
    if (new_game) begin
      word_d  = word;
      rev_d   = {WORD_LEN{UNDER}};
      miss_d  = {MAX_MISS{UNDER}};
      cnt_d   = '0;
      state_d = StPlay;
    end else if (accept) begin
      if (!is_mistake) begin
        // hit_mask bit j lines up with revealed byte j (MSB byte is char 0)
        for (int j = 0; j < int'(WORD_LEN); j++) begin
          if (hit_mask[j]) rev_d[8*j +: 8] = letter;
        end
      end else begin
        for (int k = 0; k < int'(MAX_MISS); k++) begin
          if (CntW'(k) < cnt_q && miss_q[8*(int'(MAX_MISS)-1-k) +: 8] == letter) dup = 1'b1;
        end
        if (!dup) begin
          for (int k = 0; k < int'(MAX_MISS); k++) begin
            if (CntW'(k) == cnt_q) miss_d[8*(int'(MAX_MISS)-1-k) +: 8] = letter;
          end
          cnt_d = cnt_q + 1'b1;
        end
      end
      for (int j = 0; j < int'(WORD_LEN); j++) begin
        if (rev_d[8*j +: 8] == UNDER) all_rev = 1'b0;
      end
      if (all_rev) begin
        state_d = StWin;
      end else if (cnt_d == CntW'(MAX_MISS)) begin
        state_d = StLose;
      end
    end
  end

  // Payloads are left-aligned in a COLS-wide buffer; the centring stage pads them.
  always_comb begin
    top_pl  = '0;
    bot_pl  = '0;
    top_len = '0;
    bot_len = '0;
    unique case (state_d)
      StPlay: begin
        for (int i = 0; i < int'(WORD_LEN); i++) begin
          top_pl[8*(int'(COLS)-1-i) +: 8] = rev_d[8*(int'(WORD_LEN)-1-i) +: 8];
        end
        for (int i = 0; i < int'(MAX_MISS); i++) begin
          bot_pl[8*(int'(COLS)-1-i) +: 8] = miss_d[8*(int'(MAX_MISS)-1-i) +: 8];
        end
        top_len = LenW'(WORD_LEN);
        bot_len = LenW'(MAX_MISS);
      end
      StWin, StLose: begin
        if (state_d == StWin) begin
          for (int i = 0; i < int'(WIN_LEN); i++) begin
            top_pl[8*(int'(COLS)-1-i) +: 8] = WIN_STR[8*(int'(WIN_LEN)-1-i) +: 8];
          end
          top_len = LenW'(WIN_LEN);
        end else begin
          for (int i = 0; i < int'(LOSE_LEN); i++) begin
            top_pl[8*(int'(COLS)-1-i) +: 8] = LOSE_STR[8*(int'(LOSE_LEN)-1-i) +: 8];
          end
          top_len = LenW'(LOSE_LEN);
        end
        for (int i = 0; i < int'(WORD_LEN); i++) begin
          bot_pl[8*(int'(COLS)-1-i) +: 8] = word_d[8*(int'(WORD_LEN)-1-i) +: 8];
        end
        bot_len = LenW'(WORD_LEN);
      end
      default: begin
      end
    endcase
  end

  display_row_center #(
    .COLS   (COLS),
    .MAXLEN (COLS)
  ) u_top_center (
    .payload (top_pl),
    .len     (top_len),
    .row     (top_d)
  );

  display_row_center #(
    .COLS   (COLS),
    .MAXLEN (COLS)
  ) u_bot_center (
    .payload (bot_pl),
    .len     (bot_len),
    .row     (bot_d)
  );

  assign ru_d = (top_d != top_q) || (bot_d != bot_q);

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q <= StIdle;
      word_q  <= '0;
      rev_q   <= {WORD_LEN{UNDER}};
      miss_q  <= {MAX_MISS{UNDER}};
      cnt_q   <= '0;
      top_q   <= {COLS{SPACE}};
      bot_q   <= {COLS{SPACE}};
      ru_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      rev_q   <= rev_d;
      miss_q  <= miss_d;
      cnt_q   <= cnt_d;
      top_q   <= top_d;
      bot_q   <= bot_d;
      ru_q    <= ru_d;
    end
  end

  assign top        = top_q;
  assign bottom     = bot_q;
  assign miss_count = cnt_q;
  assign game_state = state_q;
  assign row_update = ru_q;

endmodule

// File: tb/tb_hangman_host_display.sv
// Bench for hangman_host_display: directed vector table, corner sequences and
// randomized play checked against a queue-based game model.
module tb_hangman_host_display;

  localparam int WL   = 5;
  localparam int MM   = 6;
  localparam int COLS = 16;
  localparam int CW   = $clog2(MM + 1);

  logic                clk = 1'b0;
  logic                nRst = 1'b0;
  logic                new_game = 1'b0;
  logic [8*WL-1:0]     word = '0;
  logic                evt_valid = 1'b0;
  logic                evt_ready;
  logic [7:0]          letter = '0;
  logic                is_mistake = 1'b0;
  logic [WL-1:0]       hit_mask = '0;
  logic [8*COLS-1:0]   top, bottom;
  logic [CW-1:0]       miss_count;
  logic [1:0]          game_state;
  logic                row_update;

  always #5 clk = ~clk;

  hangman_host_display #(
    .WORD_LEN (WL),
    .MAX_MISS (MM),
    .COLS     (COLS)
  ) dut (
    .clk        (clk),
    .nRst       (nRst),
    .new_game   (new_game),
    .word       (word),
    .evt_valid  (evt_valid),
    .evt_ready  (evt_ready),
    .letter     (letter),
    .is_mistake (is_mistake),
    .hit_mask   (hit_mask),
    .top        (top),
    .bottom     (bottom),
    .miss_count (miss_count),
    .game_state (game_state),
    .row_update (row_update)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  int                m_st;
  int                m_cnt;
  byte unsigned      m_word[WL];
  byte unsigned      m_rev[WL];
  byte unsigned      m_miss[MM];
  logic [8*COLS-1:0] m_top, m_bot;

  function automatic logic [8*COLS-1:0] center(input byte unsigned q[$]);
    logic [8*COLS-1:0] r;
    int lead;
    r = {COLS{8'h20}};
    lead = (COLS - q.size()) / 2;
    for (int i = 0; i < q.size(); i++) r[8*(COLS-1-(lead+i)) +: 8] = q[i];
    return r;
  endfunction

  task automatic model_rows(output logic [8*COLS-1:0] t, output logic [8*COLS-1:0] b);
    byte unsigned qt[$];
    byte unsigned qb[$];
    string s;
    s = (m_st == 2) ? "Win" : "Lose";
    if (m_st == 1) begin
      for (int i = 0; i < WL; i++) qt.push_back(m_rev[i]);
      for (int i = 0; i < MM; i++) qb.push_back(m_miss[i]);
    end else if (m_st >= 2) begin
      for (int i = 0; i < s.len(); i++) qt.push_back(s[i]);
      for (int i = 0; i < WL; i++) qb.push_back(m_word[i]);
    end
    t = center(qt);
    b = center(qb);
  endtask

  task automatic model_reset();
    m_st = 0;
    m_cnt = 0;
    for (int i = 0; i < WL; i++) begin m_word[i] = 0; m_rev[i] = "_"; end
    for (int i = 0; i < MM; i++) m_miss[i] = "_";
    m_top = {COLS{8'h20}};
    m_bot = {COLS{8'h20}};
  endtask

  task automatic model_step(input bit ng, input logic [8*WL-1:0] w, input bit v,
                            input byte unsigned l, input bit m, input logic [WL-1:0] hm);
    bit found, won;
    if (ng) begin
      for (int i = 0; i < WL; i++) begin m_word[i] = w[8*(WL-1-i) +: 8]; m_rev[i] = "_"; end
      for (int i = 0; i < MM; i++) m_miss[i] = "_";
      m_cnt = 0;
      m_st = 1;
    end else if (v && m_st == 1) begin
      if (!m) begin
        for (int i = 0; i < WL; i++) if (hm[WL-1-i]) m_rev[i] = l;
      end else begin
        found = 0;
        for (int k = 0; k < m_cnt; k++) if (m_miss[k] == l) found = 1;
        if (!found) begin m_miss[m_cnt] = l; m_cnt++; end
      end
      won = 1;
      for (int i = 0; i < WL; i++) if (m_rev[i] == "_") won = 0;
      if (won) m_st = 2;
      else if (m_cnt == MM) m_st = 3;
    end
  endtask

  // Called at posedge+1; applies one cycle of stimulus and checks the result.
  task automatic apply(input bit ng, input logic [8*WL-1:0] w, input bit v,
                       input byte unsigned l, input bit m, input logic [WL-1:0] hm);
    logic [8*COLS-1:0] old_t, old_b;
    new_game = ng; word = w; evt_valid = v; letter = l; is_mistake = m; hit_mask = hm;
    #1;
    chk("evt_ready", evt_ready, (m_st == 1) && !ng);
    @(posedge clk);
    model_step(ng, w, v, l, m, hm);
    old_t = m_top;
    old_b = m_bot;
    model_rows(m_top, m_bot);
    #1;
    new_game = 0;
    evt_valid = 0;
    chk("top", top, m_top);
    chk("bottom", bottom, m_bot);
    chk("miss_count", miss_count, m_cnt);
    chk("game_state", game_state, m_st);
    chk("row_update", row_update, (m_top != old_t) || (m_bot != old_b));
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit              ng;
    logic [8*WL-1:0] w;
    bit              v;
    byte unsigned    l;
    bit              m;
    logic [WL-1:0]   hm;
    int              st;
    int              cnt;
    bit              ck_top;
    logic [127:0]    top;
    bit              ck_bot;
    logic [127:0]    bot;
  } vec_t;

  function automatic vec_t mk(input bit ng, input bit v, input byte unsigned l, input bit m,
                              input logic [WL-1:0] hm, input int st, input int cnt,
                              input bit ck_top, input logic [127:0] t,
                              input bit ck_bot, input logic [127:0] b);
    vec_t r;
    r.ng = ng; r.w = "HELLO"; r.v = v; r.l = l; r.m = m; r.hm = hm;
    r.st = st; r.cnt = cnt; r.ck_top = ck_top; r.top = t; r.ck_bot = ck_bot; r.bot = b;
    return r;
  endfunction

  localparam logic [39:0] S5 = {5{8'h20}};
  localparam logic [47:0] S6 = {6{8'h20}};
  localparam logic [55:0] S7 = {7{8'h20}};

  vec_t tbl[$];

  initial begin
    logic [8*WL-1:0] w;
    logic [WL-1:0]   hm;
    byte unsigned    l;
    bit              ng, v, m;

    tbl.push_back(mk(1, 0, 0,   0, 5'b00000, 1, 0, 1, {S5, "_____", S6}, 1, {S5, "______", S5}));
    tbl.push_back(mk(0, 1, "L", 0, 5'b00110, 1, 0, 1, {S5, "__LL_", S6}, 0, '0));
    tbl.push_back(mk(0, 1, "H", 0, 5'b10000, 1, 0, 0, '0, 0, '0));
    tbl.push_back(mk(0, 1, "E", 0, 5'b01000, 1, 0, 0, '0, 0, '0));
    tbl.push_back(mk(0, 1, "O", 0, 5'b00001, 2, 0, 1, {S6, "Win", S7}, 1, {S5, "HELLO", S6}));
    tbl.push_back(mk(1, 0, 0,   0, 5'b00000, 1, 0, 0, '0, 0, '0));
    tbl.push_back(mk(0, 1, "Z", 1, 5'b11111, 1, 1, 0, '0, 0, '0));
    tbl.push_back(mk(0, 1, "Q", 1, 5'b00000, 1, 2, 0, '0, 0, '0));
    tbl.push_back(mk(0, 1, "Z", 1, 5'b00000, 1, 2, 1, {S5, "_____", S6}, 1, {S5, "ZQ____", S5}));
    tbl.push_back(mk(0, 1, "A", 1, 5'b00000, 1, 3, 0, '0, 0, '0));
    tbl.push_back(mk(0, 1, "B", 1, 5'b00000, 1, 4, 0, '0, 0, '0));
    tbl.push_back(mk(0, 1, "C", 1, 5'b00000, 1, 5, 0, '0, 0, '0));
    tbl.push_back(mk(0, 1, "D", 1, 5'b00000, 3, 6, 1, {S6, "Lose", S6}, 1, {S5, "HELLO", S6}));
    tbl.push_back(mk(0, 1, "E", 1, 5'b00000, 3, 6, 1, {S6, "Lose", S6}, 0, '0));
    tbl.push_back(mk(1, 1, "H", 0, 5'b10000, 1, 0, 1, {S5, "_____", S6}, 1, {S5, "______", S5}));
    tbl.push_back(mk(0, 1, "X", 1, 5'b00000, 1, 1, 0, '0, 1, {S5, "X_____", S5}));

    // Reset state while nRst is held low.
    model_reset();
    #12;
    chk("rst top", top, {COLS{8'h20}});
    chk("rst bottom", bottom, {COLS{8'h20}});
    chk("rst state", game_state, 0);
    chk("rst miss_count", miss_count, 0);
    chk("rst row_update", row_update, 0);
    chk("rst evt_ready", evt_ready, 0);
    @(negedge clk);
    nRst = 1;
    @(posedge clk);
    #1;
    chk("idle evt_ready", evt_ready, 0);

    foreach (tbl[i]) begin
      apply(tbl[i].ng, tbl[i].w, tbl[i].v, tbl[i].l, tbl[i].m, tbl[i].hm);
      chk($sformatf("tbl%0d state", i), game_state, tbl[i].st);
      chk($sformatf("tbl%0d miss_count", i), miss_count, tbl[i].cnt);
      if (tbl[i].ck_top) chk($sformatf("tbl%0d top", i), top, tbl[i].top);
      if (tbl[i].ck_bot) chk($sformatf("tbl%0d bottom", i), bottom, tbl[i].bot);
    end

    // Mid-game asynchronous reset clears everything without a clock edge.
    apply(1, "WORLD", 0, 0, 0, '0);
    apply(0, "WORLD", 1, "O", 0, 5'b01000);
    @(negedge clk);
    #2;
    nRst = 0;
    #1;
    chk("async rst top", top, {COLS{8'h20}});
    chk("async rst bottom", bottom, {COLS{8'h20}});
    chk("async rst state", game_state, 0);
    chk("async rst miss_count", miss_count, 0);
    chk("async rst evt_ready", evt_ready, 0);
    model_reset();
    @(negedge clk);
    nRst = 1;
    @(posedge clk);
    #1;
    apply(0, "WORLD", 1, "W", 0, 5'b10000);
    chk("idle after rst state", game_state, 0);

    // Randomized play against the model.
    for (int n = 0; n < 400; n++) begin
      ng = (m_st != 1) ? ($urandom_range(3) == 0) : ($urandom_range(40) == 0);
      w = '0;
      for (int i = 0; i < WL; i++) w[8*(WL-1-i) +: 8] = 8'(8'h41 + $urandom_range(7));
      l = 8'(8'h41 + $urandom_range(15));
      hm = '0;
      for (int i = 0; i < WL; i++) if (m_word[i] == l) hm[WL-1-i] = 1'b1;
      m = (hm == 0);
      if (m && $urandom_range(1) == 1) hm = WL'($urandom);
      v = ($urandom_range(3) != 0);
      apply(ng, w, v, l, m, hm);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
